mdu: RTL

Multiply/divide unit for the execute stage of the five-stage MIPS pipeline. It takes the same forwarded `rs`/`rt` operands as the ALU and owns the architectural HI/LO registers. It runs MULT/MULTU/DIV/DIVU as multi-cycle operations and produces an `mdu_out` read value (MFHI/MFLO). The E-stage result mux selects between `mdu_out` and the ALU result before the E/M register. A `busy` flag tells the hazard unit to stall.

---
 rtl/mdu_pkg.sv | 33 +++
 rtl/mdu_calc.sv | 49 ++++
 rtl/mdu.sv | 113 +++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: operation codes,
// FSM states and the op-class predicates used by decode and hazard logic.
package mdu_pkg;

   typedef enum logic [3:0] {
      NONE  = 4'd0,
      MULT  = 4'd1,
      MULTU = 4'd2,
      DIV   = 4'd3,
      DIVU  = 4'd4,
      MFHI  = 4'd5,
      MFLO  = 4'd6,
      MTHI  = 4'd7,
      MTLO  = 4'd8
   } md_op_t;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } mdu_state_t;

   // True for the long-latency ops that occupy the unit for several cycles.
   function automatic logic is_muldiv(input md_op_t op);
      return (op == MULT) || (op == MULTU) || (op == DIV) || (op == DIVU);
   endfunction

   // True for any op that the MDU handles at all.
   function automatic logic is_mdu(input md_op_t op);
      return is_muldiv(op) || (op == MFHI) || (op == MFLO) ||
             (op == MTHI) || (op == MTLO);
   endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational 64-bit multiply/divide datapath. Division is done on
// magnitudes and the signs are fixed up afterwards, so the most negative
// dividend divided by -1 wraps to 0x80000000 without any special case.
module mdu_calc
   import mdu_pkg::*;
(
   input  md_op_t      op_i,
   input  logic [31:0] rs_i,
   input  logic [31:0] rt_i,
   output logic [63:0] result_o,
   output logic        div_zero_o
);

   logic [63:0] aExt;
   logic [63:0] bExt;
   logic        signedOp;
   logic [31:0] aMag;
   logic [31:0] bMag;
   logic [31:0] divisor;
   logic [31:0] qMag;
   logic [31:0] rMag;
   logic [31:0] quot;
   logic [31:0] rem;

   // Select product or quotient/remainder pair according to the op.
   always_comb begin
      result_o   = '0;
      div_zero_o = ((op_i == DIV) || (op_i == DIVU)) && (rt_i == 32'd0);
      signedOp   = (op_i == MULT) || (op_i == DIV);

      aExt = signedOp ? {{32{rs_i[31]}}, rs_i} : {32'd0, rs_i};
      bExt = signedOp ? {{32{rt_i[31]}}, rt_i} : {32'd0, rt_i};

      aMag    = (signedOp && rs_i[31]) ? (32'd0 - rs_i) : rs_i;
      bMag    = (signedOp && rt_i[31]) ? (32'd0 - rt_i) : rt_i;
      divisor = (bMag == 32'd0) ? 32'd1 : bMag;
      qMag    = aMag / divisor;
      rMag    = aMag % divisor;
      quot    = (signedOp && (rs_i[31] ^ rt_i[31])) ? (32'd0 - qMag) : qMag;
      rem     = (signedOp && rs_i[31]) ? (32'd0 - rMag) : rMag;

      case (op_i)
         MULT, MULTU: result_o = aExt * bExt;
         DIV, DIVU:   result_o = {rem, quot};
         default:     result_o = '0;
      endcase
   end

endmodule

// File: rtl/mdu.sv
// Execute-stage multiply/divide unit owning the HI/LO registers. Mul/div
// results are computed at start, held as pending, and committed after the
// configured latency; MTHI/MTLO write immediately, MFHI/MFLO are reads.
module mdu
   import mdu_pkg::*;
#(
   parameter int MUL_CYCLES = 5,
   parameter int DIV_CYCLES = 10
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [3:0]  md_op,
   input  logic [31:0] rs,
   input  logic [31:0] rt,
   output logic        busy,
   output logic [31:0] mdu_out,
   output logic [31:0] hi_out,
   output logic [31:0] lo_out
);

   localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
   localparam int CW   = $clog2(MAXC) + 1;

   md_op_t      op;
   logic [63:0] calcResult;
   logic        divZero;

   mdu_state_t  state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [31:0] pend_hi_q, pend_hi_d;
   logic [31:0] pend_lo_q, pend_lo_d;
   logic        pend_wr_q, pend_wr_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;

   assign op = md_op_t'(md_op);

   mdu_calc u_calc (
      .op_i       (op),
      .rs_i       (rs),
      .rt_i       (rt),
      .result_o   (calcResult),
      .div_zero_o (divZero)
   );

   // Next-state logic: accept ops in IDLE, count down and commit in BUSY.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      pend_hi_d = pend_hi_q;
      pend_lo_d = pend_lo_q;
      pend_wr_d = pend_wr_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               if (is_muldiv(op)) begin
                  pend_hi_d = calcResult[63:32];
                  pend_lo_d = calcResult[31:0];
                  pend_wr_d = !divZero;
                  cnt_d     = ((op == MULT) || (op == MULTU)) ?
                              CW'(MUL_CYCLES) : CW'(DIV_CYCLES);
                  state_d   = BUSY;
               end else if (op == MTHI) begin
                  hi_d = rs;
               end else if (op == MTLO) begin
                  lo_d = rs;
               end
            end
         end
         BUSY: begin
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               if (pend_wr_q) begin
                  hi_d = pend_hi_q;
                  lo_d = pend_lo_q;
               end
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State registers; reset aborts any pending result and clears HI/LO.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         pend_hi_q <= '0;
         pend_lo_q <= '0;
         pend_wr_q <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         pend_hi_q <= pend_hi_d;
         pend_lo_q <= pend_lo_d;
         pend_wr_q <= pend_wr_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
      end
   end

   assign busy    = (state_q == BUSY);
   assign hi_out  = hi_q;
   assign lo_out  = lo_q;
   assign mdu_out = (op == MFHI) ? hi_q : ((op == MFLO) ? lo_q : 32'd0);

endmodule
